fifo_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of advanced_fifo_controller between REQUESTERS independent producers.
- Each producer uses valid/ready/last streaming; the arbiter drives the FIFO write_enable/write_data and observes its full flag.
- With packet lock, a multi-beat packet from one requester lands contiguously in the FIFO.
- Sits directly in front of the FIFO controller write interface.

---
 rtl/fifo_write_arbiter_pkg.sv | 22 ++
 rtl/fifo_write_arbiter_if.sv | 38 +++
 rtl/fifo_write_arbiter_rr_encoder.sv | 49 ++++
 rtl/fifo_write_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arbiter_pkg: shared definitions for the FIFO write-port arbiter.
//   - STATE_IDLE / STATE_LOCKED : state encodings.
//   - arb_state_t               : FSM state type built from those encodings.
//   - mod_increment()           : index + 1 with an explicit wrap to 0 at
//                                 modulus - 1, so non-power-of-two requester
//                                 counts wrap correctly.
package fifo_arbiter_pkg;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    typedef enum logic {
        IDLE   = STATE_IDLE,
        LOCKED = STATE_LOCKED
    } arb_state_t;

    function automatic int unsigned mod_increment(input int unsigned index,
                                                  input int unsigned modulus);
        return (index >= modulus - 1) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester-side streaming bundle plus FIFO write port
// and grant status of the FIFO write arbiter.
//   request_valid/data/last : per-requester beat stream (data packed,
//                             requester i at [i*WIDTH +: WIDTH])
//   request_ready           : per-requester accept (one-hot or zero)
//   fifo_full               : full flag from the FIFO controller
//   fifo_write_enable/data  : write strobe and data to the FIFO controller
//   grant_valid/grant_index : current grant
//   locked                  : arbiter is holding a packet lock
// Modports: master = producers + FIFO side, slave = the arbiter.
interface fifo_write_arbiter_if #(
    parameter int REQUESTERS  = 4,
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
);
    logic [REQUESTERS-1:0]       request_valid;
    logic [REQUESTERS*WIDTH-1:0] request_data;
    logic [REQUESTERS-1:0]       request_last;
    logic [REQUESTERS-1:0]       request_ready;
    logic                        fifo_full;
    logic                        fifo_write_enable;
    logic [WIDTH-1:0]            fifo_write_data;
    logic                        grant_valid;
    logic [INDEX_WIDTH-1:0]      grant_index;
    logic                        locked;

    modport master (
        output request_valid, request_data, request_last, fifo_full,
        input  request_ready, fifo_write_enable, fifo_write_data,
               grant_valid, grant_index, locked
    );

    modport slave (
        input  request_valid, request_data, request_last, fifo_full,
        output request_ready, fifo_write_enable, fifo_write_data,
               grant_valid, grant_index, locked
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_encoder.sv
// round_robin_priority_encoder: finds the first set request bit starting at
// priority_pointer and wrapping around.
//   request          : request vector
//   priority_pointer : highest-priority index this cycle
//   found            : any request set
//   index            : winning index (valid when found)
// Two searches run in parallel: one over requests at or above the pointer,
// one over all requests. The first wins when non-empty, otherwise the
// unmasked search supplies the wrapped-around winner.
module round_robin_priority_encoder #(
    parameter int REQUESTERS  = 4,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0]  request,
    input  logic [INDEX_WIDTH-1:0] priority_pointer,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] index
);

    logic [REQUESTERS-1:0]  masked_request;
    logic                   masked_found;
    logic [INDEX_WIDTH-1:0] masked_index;
    logic [INDEX_WIDTH-1:0] raw_index;

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_mask
            assign masked_request[gi] = request[gi] && (gi >= int'(priority_pointer));
        end
    endgenerate

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        masked_found = 1'b0;
        masked_index = '0;
        raw_index    = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (masked_request[i]) begin
                masked_found = 1'b1;
                masked_index = INDEX_WIDTH'(i);
            end
            if (request[i]) begin
                raw_index = INDEX_WIDTH'(i);
            end
        end
        found = |request;
        index = masked_found ? masked_index : raw_index;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// REQUESTERS valid/ready/last producers. Zero-latency: an accepted beat is
// written to the FIFO in the same cycle, with no internal buffering.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : requester streams, FIFO write port, grant status
// Build option: define FIFO_WRITE_ARBITER_PACKET_LOCK_EN to keep a multi-beat
// packet contiguous (LOCKED state). Without it every beat is arbitrated
// individually, request_last is ignored and locked is tied to 0.
module fifo_write_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int REQUESTERS  = 4,
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input logic               clock,
    input logic               reset,
    fifo_write_arbiter_if.slave bus
);

    logic [INDEX_WIDTH-1:0] priority_pointer_reg;
    logic                   candidate_found;
    logic [INDEX_WIDTH-1:0] candidate_index;
    logic                   in_locked;
    logic [INDEX_WIDTH-1:0] owner_index;
    logic                   transfer;
    logic [WIDTH-1:0]       data_array [REQUESTERS];

    round_robin_priority_encoder #(
        .REQUESTERS (REQUESTERS),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_encoder (
        .request         (bus.request_valid),
        .priority_pointer(priority_pointer_reg),
        .found           (candidate_found),
        .index           (candidate_index)
    );

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign data_array[gi] = bus.request_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef FIFO_WRITE_ARBITER_PACKET_LOCK_EN
    arb_state_t             state_reg;
    logic [INDEX_WIDTH-1:0] locked_index_reg;

    assign in_locked  = (state_reg == LOCKED);
    assign bus.locked = in_locked;
`else
    assign in_locked  = 1'b0;
    assign bus.locked = 1'b0;
`endif

    always_comb begin
        bus.request_ready = '0;
        bus.grant_valid   = 1'b0;
        owner_index       = candidate_index;
        if (!reset) begin
`ifdef FIFO_WRITE_ARBITER_PACKET_LOCK_EN
            if (in_locked) begin
                // Lock owner keeps the port even while its valid is low.
                owner_index                    = locked_index_reg;
                bus.grant_valid                = 1'b1;
                bus.request_ready[owner_index] = !bus.fifo_full;
            end else
`endif
            begin
                bus.grant_valid = candidate_found;
                if (candidate_found) begin
                    bus.request_ready[owner_index] = !bus.fifo_full;
                end
            end
        end
    end

    assign transfer              = |(bus.request_valid & bus.request_ready);
    assign bus.fifo_write_enable = transfer;
    assign bus.fifo_write_data   = data_array[owner_index];
    assign bus.grant_index       = owner_index;

    always_ff @(posedge clock) begin
        if (reset) begin
            priority_pointer_reg <= '0;
`ifdef FIFO_WRITE_ARBITER_PACKET_LOCK_EN
            state_reg        <= IDLE;
            locked_index_reg <= '0;
`endif
        end else if (transfer) begin
            // The pointer only moves on a fresh grant; inside a packet it
            // already points past the owner.
            if (!in_locked) begin
                priority_pointer_reg <= INDEX_WIDTH'(mod_increment(32'(candidate_index),
                                                                   REQUESTERS));
            end
`ifdef FIFO_WRITE_ARBITER_PACKET_LOCK_EN
            if (in_locked) begin
                if (bus.request_last[locked_index_reg]) begin
                    state_reg <= IDLE;
                end
            end else if (!bus.request_last[candidate_index]) begin
                state_reg        <= LOCKED;
                locked_index_reg <= candidate_index;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: a 4-requester instance driven by per-
// requester beat queues and checked against an expected-write scoreboard,
// plus a 3-requester instance for the non-power-of-two wrap.
// Expected orders depend on FIFO_WRITE_ARBITER_PACKET_LOCK_EN.
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       lock;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    exp_t       exp_q [$];
    logic [8:0] beat_q [N][$];   // {last, data}

    always #5 clock = ~clock;

    fifo_write_arbiter_if #(.REQUESTERS(4), .WIDTH(8)) bus4 ();
    fifo_write_arbiter_if #(.REQUESTERS(3), .WIDTH(8)) bus3 ();

    fifo_write_arbiter #(.REQUESTERS(4), .WIDTH(8)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4)
    );
    fifo_write_arbiter #(.REQUESTERS(3), .WIDTH(8)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3)
    );

`ifdef FIFO_WRITE_ARBITER_PACKET_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    task automatic drive4();
        for (int i = 0; i < N; i++) begin
            bus4.request_valid[i] = (beat_q[i].size() > 0);
            if (beat_q[i].size() > 0) begin
                bus4.request_data[i*W +: W] = beat_q[i][0][7:0];
                bus4.request_last[i]        = beat_q[i][0][8];
            end else begin
                bus4.request_data[i*W +: W] = '0;
                bus4.request_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int req, input logic [7:0] data, input logic last);
        beat_q[req].push_back({last, data});
    endtask

    task automatic expect_write(input int idx, input logic [7:0] data, input logic lock);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = data;
        e.lock = lock;
        exp_q.push_back(e);
    endtask

    // One cycle: sample at negedge, compare any write against the scoreboard,
    // then retire accepted beats after the edge and redrive.
    task automatic step();
        logic [N-1:0] acc;
        exp_t         e;
        @(negedge clock);
        acc = bus4.request_ready & bus4.request_valid;
        if (bus4.fifo_write_enable) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got idx=%0d data=%h, required no write",
                         bus4.grant_index, bus4.fifo_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus4.grant_valid, bus4.grant_index, bus4.fifo_write_data,
                     bus4.locked, bus4.request_ready} !==
                    {1'b1, e.idx, e.data, e.lock, 4'b0001 << e.idx}) begin
                    failed++;
                    $display("FAIL write_beat: got gv=%b idx=%0d data=%h locked=%b ready=%b, required gv=1 idx=%0d data=%h locked=%b ready=%b",
                             bus4.grant_valid, bus4.grant_index, bus4.fifo_write_data,
                             bus4.locked, bus4.request_ready, e.idx, e.data, e.lock,
                             4'b0001 << e.idx);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(beat_q[i].pop_front());
        end
        drive4();
    endtask

    task automatic run_until_done(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            step();
            cycles++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d writes outstanding after %0d cycles, required 0",
                     exp_q.size(), cycles);
            exp_q.delete();
            for (int i = 0; i < N; i++) beat_q[i].delete();
            drive4();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) push_beat(i, 8'(8'h10 + i), 1'b1);
        push_beat(0, 8'h50, 1'b1);
        drive4();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            tests++;
            if ({bus4.request_ready, bus4.fifo_write_enable, bus4.grant_valid, bus4.locked} !== 7'b0) begin
                failed++;
                $display("FAIL reset_outputs: got ready=%b we=%b gv=%b locked=%b, required all 0",
                         bus4.request_ready, bus4.fifo_write_enable, bus4.grant_valid, bus4.locked);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int cycles;
        for (int i = 0; i < N; i++) expect_write(i, 8'(8'h10 + i), 1'b0);
        expect_write(0, 8'h50, 1'b0);
        run_until_done(20, cycles);
        tests++;
        if (cycles != 5) begin
            failed++;
            $display("FAIL rr_back_to_back: got %0d cycles, required 5", cycles);
        end
    endtask

    task automatic test_packet_lock();
        int cycles;
        push_beat(2, 8'h21, 1'b0);
        push_beat(2, 8'h22, 1'b0);
        push_beat(2, 8'h23, 1'b1);
        push_beat(0, 8'h0A, 1'b1);
        push_beat(3, 8'h3A, 1'b1);
        drive4();
        if (LOCK_EN) begin
            expect_write(2, 8'h21, 1'b0);
            expect_write(2, 8'h22, 1'b1);
            expect_write(2, 8'h23, 1'b1);
            expect_write(3, 8'h3A, 1'b0);
            expect_write(0, 8'h0A, 1'b0);
        end else begin
            expect_write(2, 8'h21, 1'b0);
            expect_write(3, 8'h3A, 1'b0);
            expect_write(0, 8'h0A, 1'b0);
            expect_write(2, 8'h22, 1'b0);
            expect_write(2, 8'h23, 1'b0);
        end
        run_until_done(20, cycles);
    endtask

    task automatic test_full_mid_packet();
        int cycles;
        push_beat(1, 8'h31, 1'b0);
        push_beat(1, 8'h32, 1'b0);
        push_beat(1, 8'h33, 1'b1);
        push_beat(0, 8'h30, 1'b1);
        drive4();
        if (LOCK_EN) begin
            expect_write(1, 8'h31, 1'b0);
            expect_write(1, 8'h32, 1'b1);
            expect_write(1, 8'h33, 1'b1);
            expect_write(0, 8'h30, 1'b0);
        end else begin
            expect_write(0, 8'h30, 1'b0);
            expect_write(1, 8'h31, 1'b0);
            expect_write(1, 8'h32, 1'b0);
            expect_write(1, 8'h33, 1'b0);
        end
        cycles = 0;
        while (exp_q.size() == 4 && cycles < 5) begin
            step();
            cycles++;
        end
        bus4.fifo_full = 1'b1;
        repeat (2) begin
            @(negedge clock);
            tests++;
            if ({bus4.request_ready, bus4.fifo_write_enable, bus4.grant_valid, bus4.grant_index} !==
                {4'b0000, 1'b0, 1'b1, 2'd1}) begin
                failed++;
                $display("FAIL full_stall: got ready=%b we=%b gv=%b idx=%0d, required ready=0000 we=0 gv=1 idx=1",
                         bus4.request_ready, bus4.fifo_write_enable, bus4.grant_valid, bus4.grant_index);
            end
            @(posedge clock);
            #1;
        end
        bus4.fifo_full = 1'b0;
        run_until_done(20, cycles);
    endtask

    task automatic test_idle();
        drive4();
        @(negedge clock);
        tests++;
        if ({bus4.grant_valid, bus4.fifo_write_enable, bus4.request_ready} !== 6'b0) begin
            failed++;
            $display("FAIL idle_no_grant: got gv=%b we=%b ready=%b, required all 0",
                     bus4.grant_valid, bus4.fifo_write_enable, bus4.request_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_interleave();
        int cycles;
        push_beat(1, 8'h41, 1'b0);
        push_beat(1, 8'h42, 1'b1);
        push_beat(2, 8'h51, 1'b0);
        push_beat(2, 8'h52, 1'b1);
        drive4();
        if (LOCK_EN) begin
            expect_write(1, 8'h41, 1'b0);
            expect_write(1, 8'h42, 1'b1);
            expect_write(2, 8'h51, 1'b0);
            expect_write(2, 8'h52, 1'b1);
        end else begin
            expect_write(2, 8'h51, 1'b0);
            expect_write(1, 8'h41, 1'b0);
            expect_write(2, 8'h52, 1'b0);
            expect_write(1, 8'h42, 1'b0);
        end
        run_until_done(20, cycles);
    endtask

    task automatic check3(input string name, input logic [1:0] idx, input logic [7:0] data);
        @(negedge clock);
        tests++;
        if ({bus3.grant_valid, bus3.grant_index, bus3.fifo_write_enable,
             bus3.fifo_write_data, bus3.request_ready} !==
            {1'b1, idx, 1'b1, data, 3'b001 << idx}) begin
            failed++;
            $display("FAIL %s: got gv=%b idx=%0d we=%b data=%h ready=%b, required gv=1 idx=%0d we=1 data=%h ready=%b",
                     name, bus3.grant_valid, bus3.grant_index, bus3.fifo_write_enable,
                     bus3.fifo_write_data, bus3.request_ready, idx, data, 3'b001 << idx);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wrap3();
        bus3.request_data = {8'hC2, 8'hC1, 8'hC0};
        bus3.request_last = 3'b111;
        bus3.request_valid = 3'b100;
        check3("wrap3_grant2", 2'd2, 8'hC2);
        bus3.request_valid = 3'b011;
        check3("wrap3_grant0", 2'd0, 8'hC0);
        bus3.request_valid = 3'b111;
        check3("wrap3_grant1", 2'd1, 8'hC1);
        bus3.request_valid = 3'b000;
    endtask

    initial begin
        bus4.fifo_full     = 1'b0;
        bus4.request_valid = '0;
        bus4.request_data  = '0;
        bus4.request_last  = '0;
        bus3.fifo_full     = 1'b0;
        bus3.request_valid = '0;
        bus3.request_data  = '0;
        bus3.request_last  = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_round_robin();
        test_idle();
        test_packet_lock();
        test_full_mid_packet();
        test_interleave();
        test_idle();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
